// File: rtl/axis_pkg.sv
// Shared AXI-stream helpers: packed word sizing and tlast placement for the FIFO controller.
package axis_pkg;

  typedef struct packed {
    logic [7:0] data_w;
    logic [7:0] user_w;
  } axis_cfg_t;

  // Packed word = tdata + tuser + tlast (tlast on top).
  function automatic int unsigned axis_word_width(axis_cfg_t cfg);
    return 32'(cfg.data_w) + 32'(cfg.user_w) + 32'd1;
  endfunction

  function automatic int unsigned axis_fifo_tlast_bit(int unsigned w);
    return w - 32'd1;
  endfunction

endpackage

// File: rtl/axis_fifo_ctrl_obuf.sv
// Two-entry output prefetch FIFO that hides the one-cycle RAM read latency.
module axis_fifo_ctrl_obuf #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         head_q, head_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         wr_idx;

  assign wr_idx  = head_q ^ cnt_q[0];
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[head_q];
  assign cnt_o   = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    if (push_i) mem_d[wr_idx] = push_data_i;
    if (pop_i) head_d = ~head_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axis_fifo_ctrl.sv
// AXI-stream FIFO controller sequencing an external 1W/1R RAM with a 2-entry output prefetch.
// Define AXIS_FIFO_CTRL_PACKET_MODE_EN for store-and-forward (adds pkt_oversize).
module axis_fifo_ctrl
  import axis_pkg::*;
#(
  parameter  int unsigned W  = 9,
  parameter  int unsigned D  = 16,
  localparam int unsigned AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_tvalid,
  output logic          in_tready,
  input  logic [W-1:0]  wr_data,
  output logic          out_tvalid,
  input  logic          out_tready,
  output logic [W-1:0]  rd_data,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [W-1:0]  ram_wr_data,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [W-1:0]  ram_rd_q,
  output logic [AW:0]   count,
  output logic          full,
`ifdef AXIS_FIFO_CTRL_PACKET_MODE_EN
  output logic          pkt_oversize,
`endif
  output logic          empty
);

  localparam logic [AW:0]   FullCnt = D[AW:0];
  localparam logic [AW:0]   CntOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PtrOne  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    obuf_cnt;
  logic          wr_fire, rd_fire, pop, pkt_gate;

  assign full        = (count_q == FullCnt);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign in_tready   = ~reset & ~full;
  assign wr_fire     = in_tvalid & in_tready;
  assign pop         = out_tvalid & out_tready;
  assign ram_wr_en   = wr_fire;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = wr_data;

  // A same-cycle pop frees a buffer slot, which keeps reads streaming at one word per cycle.
  assign rd_fire = ~reset & (ram_cnt_q != '0) & pkt_gate &
                   (({1'b0, obuf_cnt} + {2'b00, inflight_q}) < ({2'b00, pop} + 3'd2));
  assign ram_rd_en   = rd_fire;
  assign ram_rd_addr = rd_ptr_q;

  always_comb begin
    wr_ptr_d   = wr_fire ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = rd_fire ? rd_ptr_q + PtrOne : rd_ptr_q;
    inflight_d = rd_fire;
    case ({wr_fire, rd_fire})
      2'b10:   ram_cnt_d = ram_cnt_q + CntOne;
      2'b01:   ram_cnt_d = ram_cnt_q - CntOne;
      default: ram_cnt_d = ram_cnt_q;
    endcase
    case ({wr_fire, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  axis_fifo_ctrl_obuf #(
    .W (W)
  ) u_obuf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (ram_rd_q),
    .pop_i       (pop),
    .valid_o     (out_tvalid),
    .data_o      (rd_data),
    .cnt_o       (obuf_cnt)
  );

`ifdef AXIS_FIFO_CTRL_PACKET_MODE_EN
  localparam int unsigned TlastBit = axis_fifo_tlast_bit(W);

  logic [D-1:0] last_q, last_d;
  logic [AW:0]  pkt_cnt_q, pkt_cnt_d;
  logic         oversize_q, oversize_d;
  logic         ram_full;

  // A full RAM with no complete packet must still drain or the writer deadlocks.
  assign ram_full     = (ram_cnt_q == FullCnt);
  assign pkt_gate     = (pkt_cnt_q != '0) | ram_full;
  assign pkt_oversize = oversize_q;

  always_comb begin
    last_d = last_q;
    if (wr_fire) last_d[wr_ptr_q] = wr_data[TlastBit];
    case ({wr_fire & wr_data[TlastBit], rd_fire & last_q[rd_ptr_q]})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CntOne;
      2'b01:   pkt_cnt_d = pkt_cnt_q - CntOne;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    oversize_d = rd_fire & (pkt_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= '0;
      pkt_cnt_q  <= '0;
      oversize_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      pkt_cnt_q  <= pkt_cnt_d;
      oversize_q <= oversize_d;
    end
  end
`else
  assign pkt_gate = 1'b1;
`endif

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Bench for axis_fifo_ctrl: queue reference model, behavioural RAM, directed and random traffic.
module tb_axis_fifo_ctrl;

  localparam int unsigned W  = 9;
  localparam int unsigned D  = 16;
  localparam int unsigned AW = $clog2(D);
`ifdef AXIS_FIFO_CTRL_PACKET_MODE_EN
  localparam logic [W-1:0] LastBit = 9'h100;
`else
  localparam logic [W-1:0] LastBit = 9'h000;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic [W-1:0]  wr_data = '0;
  logic          out_tvalid;
  logic          out_tready = 1'b0;
  logic [W-1:0]  rd_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [W-1:0]  ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [W-1:0]  ram_rd_q;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
`ifdef AXIS_FIFO_CTRL_PACKET_MODE_EN
  logic          pkt_oversize;
  int            oversize_seen;
`endif

  always #5 clk = ~clk;

  axis_fifo_ctrl #(
    .W (W),
    .D (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_tvalid    (in_tvalid),
    .in_tready    (in_tready),
    .wr_data      (wr_data),
    .out_tvalid   (out_tvalid),
    .out_tready   (out_tready),
    .rd_data      (rd_data),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_q     (ram_rd_q),
    .count        (count),
    .full         (full),
`ifdef AXIS_FIFO_CTRL_PACKET_MODE_EN
    .pkt_oversize (pkt_oversize),
`endif
    .empty        (empty)
  );

  // Behavioural RAM: registered read, one cycle latency.
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_q <= mem[ram_rd_addr];
  end

  int           tests = 0;
  int           fails = 0;
  int           pops  = 0;
  logic [W-1:0] model_q [$];
  logic         acc, popped;
  logic [W-1:0] pop_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check against model, then account for handshakes.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    in_tvalid  = v;
    wr_data    = d;
    out_tready = r;
    #1;
    chk("count", 32'(count), 32'(model_q.size()));
    chk("full", 32'(full), 32'(model_q.size() == D));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("in_tready", 32'(in_tready), 32'(model_q.size() < D));
    chk("ram_wr_en", 32'(ram_wr_en), 32'(v & (model_q.size() < D)));
    chk("ram_wr_data", 32'(ram_wr_data), 32'(d));
    acc    = v & in_tready;
    popped = out_tvalid & out_tready;
    if (popped) begin
      pops++;
      pop_data = rd_data;
      chk("pop_data", 32'(rd_data), model_q.size() != 0 ? 32'(model_q[0]) : {32{1'bx}});
      if (model_q.size() != 0) void'(model_q.pop_front());
    end
    if (acc) model_q.push_back(d);
`ifdef AXIS_FIFO_CTRL_PACKET_MODE_EN
    if (pkt_oversize) oversize_seen++;
`endif
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset      = 1'b1;
    in_tvalid  = 1'b1;
    wr_data    = 9'h155;
    out_tready = 1'b1;
    #1;
    chk("rst_in_tready", 32'(in_tready), 32'd0);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    repeat (cycles - 1) @(negedge clk);
    @(negedge clk);
    reset      = 1'b0;
    in_tvalid  = 1'b0;
    out_tready = 1'b0;
    model_q.delete();
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready_after", 32'(in_tready), 32'd1);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_wr_en_after", 32'(ram_wr_en), 32'd0);
`ifdef AXIS_FIFO_CTRL_PACKET_MODE_EN
    chk("rst_oversize", 32'(pkt_oversize), 32'd0);
`endif
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (model_q.size() != 0 && n < budget) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    chk("drain_done", 32'(model_q.size()), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sent, first, gaps, n;

    do_reset(2);

    // Single word latency.
    step(1'b1, 9'h0A5 | LastBit, 1'b1);
    chk("t1_acc", 32'(acc), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, '0, 1'b1);
      chk("t1_latency", 32'(out_tvalid), 32'(i == 3));
    end
    chk("t1_data", 32'(pop_data), 32'(9'h0A5 | LastBit));
    step(1'b0, '0, 1'b1);
    chk("t1_count0", 32'(count), 32'd0);

    // Fill to full with back-pressure, then pop one.
    for (int i = 0; i < 16; i++) step(1'b1, W'(i) | LastBit, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_not_ready", 32'(in_tready), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("t2_pop", 32'(popped), 32'd1);
    step(1'b0, '0, 1'b0);
    chk("t2_ready", 32'(in_tready), 32'd1);
    chk("t2_count", 32'(count), 32'd15);
    drain(60);

    // Streaming across pointer wrap.
    base = pops; sent = 0; first = -1; gaps = 0; n = 0;
    while (pops - base < 100 && n < 200) begin
      step(sent < 100, W'(sent) | LastBit, 1'b1);
      if (acc) sent++;
      if (popped && first < 0) first = n;
      else if (!popped && first >= 0) gaps++;
      n++;
    end
    chk("t3_words", 32'(pops - base), 32'd100);
    chk("t3_first", 32'(first), 32'd3);
    chk("t3_gaps", 32'(gaps), 32'd0);
    drain(10);

    // Random traffic against the queue model.
    base = pops; n = 0;
    while (pops - base < 2000 && n < 10000) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
      n++;
    end
    chk("t4_words", 32'(pops - base), 32'd2000);

    // Reset with stored words and a read in flight.
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h30 + i) | LastBit, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("t5_pop", 32'(popped), 32'd1);
    chk("t5_rd_en", 32'(ram_rd_en), 32'd1);
    do_reset(1);
    step(1'b0, '0, 1'b1);
    chk("t5_idle", 32'(out_tvalid), 32'd0);
    base = pops;
    step(1'b1, 9'h1FF, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    chk("t5_one_word", 32'(pops - base), 32'd1);
    chk("t5_data", 32'(pop_data), 32'h1FF);

`ifdef AXIS_FIFO_CTRL_PACKET_MODE_EN
    // Incomplete packet is held until tlast arrives.
    do_reset(1);
    oversize_seen = 0;
    base = pops;
    for (int i = 0; i < 4; i++) step(1'b1, W'(64 + i), 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1);
      chk("t6_hold", 32'(out_tvalid), 32'd0);
    end
    step(1'b1, 9'h145, 1'b1);
    drain(20);
    chk("t6_words", 32'(pops - base), 32'd5);
    chk("t6_no_oversize", 32'(oversize_seen), 32'd0);

    // Packet longer than the FIFO drains through the full override.
    do_reset(1);
    oversize_seen = 0;
    base = pops; sent = 0; n = 0;
    while (sent < 20 && n < 300) begin
      step(1'b1, (sent == 19) ? (W'(sent) | LastBit) : W'(sent), 1'b1);
      if (acc) sent++;
      n++;
    end
    drain(100);
    chk("t7_words", 32'(pops - base), 32'd20);
    chk("t7_oversize", 32'(oversize_seen > 0), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
